// File: rtl/vgalab_pkg.sv
// vgalab_pkg: shared definitions for the player movement path.
// Holds PS/2 scan-code constants, the key-decoder state encoding,
// held-flag bit positions and the clamped single-axis step helper.
package vgalab_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  // plain (WASD) codes
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  // E0-prefixed arrow codes
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int HELD_UP    = 3;
  localparam int HELD_DOWN  = 2;
  localparam int HELD_LEFT  = 1;
  localparam int HELD_RIGHT = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] mask;
  } key_hit_t;

  function automatic key_hit_t map_plain(input logic [7:0] b);
    key_hit_t r;
    r = '0;
    case (b)
      SC_W:    r = '{hit: 1'b1, mask: 4'b1000};
      SC_S:    r = '{hit: 1'b1, mask: 4'b0100};
      SC_A:    r = '{hit: 1'b1, mask: 4'b0010};
      SC_D:    r = '{hit: 1'b1, mask: 4'b0001};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic key_hit_t map_ext(input logic [7:0] b);
    key_hit_t r;
    r = '0;
    case (b)
      SC_UP:    r = '{hit: 1'b1, mask: 4'b1000};
      SC_DOWN:  r = '{hit: 1'b1, mask: 4'b0100};
      SC_LEFT:  r = '{hit: 1'b1, mask: 4'b0010};
      SC_RIGHT: r = '{hit: 1'b1, mask: 4'b0001};
      default:  r = '0;
    endcase
    return r;
  endfunction

  // One axis step, saturating at 0 and maxv. Done in 11 bits so that
  // neither pos+step nor pos-step can wrap. Opposing keys cancel.
  function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                           input logic        inc,
                                           input logic        dec,
                                           input logic [10:0] maxv,
                                           input logic [10:0] stepv);
    logic [10:0] p;
    logic [10:0] r;
    p = {1'b0, pos};
    r = p;
    if (inc && !dec) begin
      r = (p > maxv - stepv) ? maxv : p + stepv;
    end else if (dec && !inc) begin
      r = (p < stepv) ? 11'd0 : p - stepv;
    end
    return r[9:0];
  endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns the PS/2 received-byte stream into held-direction
// flags. Handles make/break (F0) and extended (E0) prefixes; a prefix
// left dangling for TIMEOUT cycles is abandoned and flagged in proto_err.
// Ports: clk, rst (async, high), ps2_data/ps2_valid (byte strobe in),
//        held {up,down,left,right}, proto_err (sticky until rst).
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | waiting for a plain code or a prefix byte
// ST_EXT     | E0 seen, next byte is an extended make code or F0
// ST_BRK     | F0 seen, next byte is a plain code to release
// ST_EXT_BRK | E0 F0 seen, next byte is an extended code to release
module ps2_key_tracker
  import vgalab_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  output logic [3:0] held,
  output logic       proto_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dec_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    held_q, held_d;
  logic          err_q, err_d;
  key_hit_t      plain, ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    held_d  = held_q;
    err_d   = err_q;
    plain   = map_plain(ps2_data);
    ext     = map_ext(ps2_data);
    if (ps2_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_EXT)      state_d = ST_EXT;
          else if (ps2_data == SC_BRK) state_d = ST_BRK;
          else if (plain.hit)          held_d  = held_q | plain.mask;
        end
        ST_EXT: begin
          if (ps2_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            if (ext.hit) held_d = held_q | ext.mask;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (plain.hit) held_d = held_q & ~plain.mask;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (ext.hit) held_d = held_q & ~ext.mask;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // Stuck mid-sequence: drop the prefix, keep the flags as they are.
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign held      = held_q;
  assign proto_err = err_q;

endmodule

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: once-per-frame player position stepping.
// Synchronises the active-low VGA vsync, detects its falling edge as the
// frame tick, and on each tick (when enable=1) moves the player by STEP
// along each axis per the held keys, saturating at 0 and X_MAX/Y_MAX.
// Ports: clk, rst (async, high), ps2_data/ps2_valid (from PS/2 receiver),
//        vga_vs (async vsync), enable, xpos/ypos (to renderer), held,
//        frame_tick (one-cycle pulse), proto_err (sticky decoder error).
module player_move_ctrl
  import vgalab_pkg::*;
#(
  parameter int X_INIT  = 320,
  parameter int Y_INIT  = 240,
  parameter int X_MAX   = 634,
  parameter int Y_MAX   = 474,
  parameter int STEP    = 2,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  input  logic       vga_vs,
  input  logic       enable,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [3:0] held,
  output logic       frame_tick,
  output logic       proto_err
);

  localparam logic [10:0] X_MAX_W = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_W = 11'(Y_MAX);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  logic       vs_meta_q, vs_meta_d;
  logic       vs_sync_q, vs_sync_d;
  logic       vs_dly_q,  vs_dly_d;
  logic       frame_tick_q, frame_tick_d;
  logic [9:0] xpos_q, xpos_d;
  logic [9:0] ypos_q, ypos_d;
  logic [3:0] held_w;

  ps2_key_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .ps2_data  (ps2_data),
    .ps2_valid (ps2_valid),
    .held      (held_w),
    .proto_err (proto_err)
  );

  // Sync flops reset high (vsync idle level) so reset never fakes a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_q    <= 1'b1;
      vs_sync_q    <= 1'b1;
      vs_dly_q     <= 1'b1;
      frame_tick_q <= 1'b0;
      xpos_q       <= 10'(X_INIT);
      ypos_q       <= 10'(Y_INIT);
    end else begin
      vs_meta_q    <= vs_meta_d;
      vs_sync_q    <= vs_sync_d;
      vs_dly_q     <= vs_dly_d;
      frame_tick_q <= frame_tick_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
    end
  end

  // held_w here is the pre-byte value when ps2_valid coincides with the
  // tick, so a key pressed on the tick cycle moves on the next frame.
  always_comb begin
    vs_meta_d    = vga_vs;
    vs_sync_d    = vs_meta_q;
    vs_dly_d     = vs_sync_q;
    frame_tick_d = vs_dly_q & ~vs_sync_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    if (frame_tick_q && enable) begin
      xpos_d = step_axis(xpos_q, held_w[HELD_RIGHT], held_w[HELD_LEFT],
                         X_MAX_W, STEP_W);
      ypos_d = step_axis(ypos_q, held_w[HELD_DOWN], held_w[HELD_UP],
                         Y_MAX_W, STEP_W);
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign held       = held_w;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
module tb_player_move_ctrl;

  localparam int TMO = 20;

  logic       clk;
  logic       rst;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       vga_vs;
  logic       enable;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic [3:0] held;
  logic       frame_tick;
  logic       proto_err;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;

  player_move_ctrl #(
    .X_INIT(320), .Y_INIT(240), .X_MAX(634), .Y_MAX(474),
    .STEP(2), .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_data   (ps2_data),
    .ps2_valid  (ps2_valid),
    .vga_vs     (vga_vs),
    .enable     (enable),
    .xpos       (xpos),
    .ypos       (ypos),
    .held       (held),
    .frame_tick (frame_tick),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame_tick) tick_cnt++;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ps2_data  = b;
    ps2_valid = 1'b1;
    @(negedge clk);
    ps2_valid = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    vga_vs = 1'b0;
    repeat (6) @(negedge clk);
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (xpos !== 10'd320) begin n_err++; $display("FAIL reset_xpos got=%0d exp=320", xpos); end
    n_cmp++; if (ypos !== 10'd240) begin n_err++; $display("FAIL reset_ypos got=%0d exp=240", ypos); end
    n_cmp++; if (held !== 4'b0000) begin n_err++; $display("FAIL reset_held got=%b exp=0000", held); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", proto_err); end
  endtask

  task automatic test_idle_frames();
    int t0;
    t0 = tick_cnt;
    repeat (3) frame();
    n_cmp++; if (tick_cnt - t0 !== 3) begin n_err++; $display("FAIL idle_ticks got=%0d exp=3", tick_cnt - t0); end
    n_cmp++; if (xpos !== 10'd320 || ypos !== 10'd240) begin
      n_err++; $display("FAIL idle_pos got=%0d,%0d exp=320,240", xpos, ypos);
    end
  endtask

  task automatic test_ext_right();
    send_byte(8'hE0); send_byte(8'h74);
    n_cmp++; if (held !== 4'b0001) begin n_err++; $display("FAIL ext_make_held got=%b exp=0001", held); end
    repeat (4) frame();
    n_cmp++; if (xpos !== 10'd328) begin n_err++; $display("FAIL ext_move_x got=%0d exp=328", xpos); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    n_cmp++; if (held !== 4'b0000) begin n_err++; $display("FAIL ext_brk_held got=%b exp=0000", held); end
    repeat (2) frame();
    n_cmp++; if (xpos !== 10'd328 || ypos !== 10'd240) begin
      n_err++; $display("FAIL ext_stop_pos got=%0d,%0d exp=328,240", xpos, ypos);
    end
  endtask

  task automatic test_shared_flag();
    send_byte(8'h23); send_byte(8'hE0); send_byte(8'h74);
    n_cmp++; if (held !== 4'b0001) begin n_err++; $display("FAIL both_right_held got=%b exp=0001", held); end
    send_byte(8'hF0); send_byte(8'h23);
    n_cmp++; if (held !== 4'b0000) begin n_err++; $display("FAIL shared_release got=%b exp=0000", held); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
    send_byte(8'h1C); send_byte(8'h23);
    send_byte(8'h23);  // typematic repeat
    n_cmp++; if (held !== 4'b0011) begin n_err++; $display("FAIL ad_held got=%b exp=0011", held); end
    frame();
    n_cmp++; if (xpos !== 10'd328) begin n_err++; $display("FAIL ad_cancel_x got=%0d exp=328", xpos); end
    send_byte(8'hF0); send_byte(8'h1C);
    enable = 1'b0;
    frame();
    n_cmp++; if (xpos !== 10'd328) begin n_err++; $display("FAIL disabled_x got=%0d exp=328", xpos); end
    n_cmp++; if (held !== 4'b0001) begin n_err++; $display("FAIL disabled_held got=%b exp=0001", held); end
    enable = 1'b1;
    frame();
    n_cmp++; if (xpos !== 10'd330) begin n_err++; $display("FAIL enabled_x got=%0d exp=330", xpos); end
  endtask

  task automatic test_clamp();
    logic       rose;
    logic [9:0] prev;
    // x saturates at X_MAX: 330 + 2*152 = 634, a few extra frames must hold it
    repeat (160) frame();
    n_cmp++; if (xpos !== 10'd634) begin n_err++; $display("FAIL clamp_xmax got=%0d exp=634", xpos); end
    send_byte(8'hF0); send_byte(8'h23);
    send_byte(8'h1D);
    rose = 1'b0;
    prev = ypos;
    for (int i = 0; i < 125; i++) begin
      frame();
      if (ypos > prev) rose = 1'b1;
      prev = ypos;
    end
    n_cmp++; if (ypos !== 10'd0) begin n_err++; $display("FAIL clamp_ymin got=%0d exp=0", ypos); end
    n_cmp++; if (rose !== 1'b0) begin n_err++; $display("FAIL clamp_no_wrap got=%b exp=0", rose); end
    send_byte(8'hF0); send_byte(8'h1D);
    n_cmp++; if (held !== 4'b0000) begin n_err++; $display("FAIL clamp_release got=%b exp=0000", held); end
  endtask

  task automatic test_timeout();
    send_byte(8'hE0);
    repeat (TMO - 3) @(negedge clk);
    n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL tmo_early got=%b exp=0", proto_err); end
    repeat (4) @(negedge clk);
    n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL tmo_err got=%b exp=1", proto_err); end
    send_byte(8'h75);
    n_cmp++; if (held !== 4'b0000) begin n_err++; $display("FAIL tmo_plain75 got=%b exp=0000", held); end
    send_byte(8'h1B);
    n_cmp++; if (held !== 4'b0100) begin n_err++; $display("FAIL tmo_idle_after got=%b exp=0100", held); end
    send_byte(8'hF0); send_byte(8'h1B);
  endtask

  task automatic test_coincident();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b0 || ypos !== 10'd240) begin
      n_err++; $display("FAIL rst_clears got=%b,%0d exp=0,240", proto_err, ypos);
    end
    vga_vs = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL tick_latency got=%b exp=1", frame_tick); end
    ps2_data  = 8'h1D;
    ps2_valid = 1'b1;
    @(negedge clk);
    ps2_valid = 1'b0;
    repeat (3) @(negedge clk);
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (ypos !== 10'd240) begin n_err++; $display("FAIL coinc_same_frame got=%0d exp=240", ypos); end
    n_cmp++; if (held !== 4'b1000) begin n_err++; $display("FAIL coinc_held got=%b exp=1000", held); end
    frame();
    n_cmp++; if (ypos !== 10'd238) begin n_err++; $display("FAIL coinc_next_frame got=%0d exp=238", ypos); end
    // mid-frame, mid-sequence reset
    send_byte(8'hE0);
    vga_vs = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (xpos !== 10'd320 || ypos !== 10'd240 || held !== 4'b0000) begin
      n_err++; $display("FAIL midframe_rst got=%0d,%0d,%b exp=320,240,0000", xpos, ypos, held);
    end
    @(negedge clk);
    vga_vs = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_byte(8'h74);  // would be right-arrow if E0 had survived reset
    n_cmp++; if (held !== 4'b0000) begin n_err++; $display("FAIL rst_drops_prefix got=%b exp=0000", held); end
  endtask

  initial begin
    rst       = 1'b1;
    ps2_data  = 8'h00;
    ps2_valid = 1'b0;
    vga_vs    = 1'b1;
    enable    = 1'b1;
    test_reset();
    test_idle_frames();
    test_ext_right();
    test_shared_flag();
    test_clamp();
    test_timeout();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Movement controller that sequences updates to the local player position consumed by the textbox renderer and exported as `sendxpos`/`sendypos`. It decodes the PS/2 controller's received byte stream (make/break, extended prefix) into held-direction flags. Once per video frame, on the VGA vertical-sync edge, it steps the player coordinates within the screen bounds. It replaces the switch-driven movement path and sits between `PS2_Controller` and `textbox` in the top level.

## Interface
Parameters:
- `X_INIT`, 320, x position after reset
- `Y_INIT`, 240, y position after reset
- `X_MAX`, 634, largest legal x (640 − 6-pixel sprite); minimum x is 0
- `Y_MAX`, 474, largest legal y (480 − 6); minimum y is 0
- `STEP`, 2, pixels moved per frame per axis (1..15)
- `TIMEOUT`, 50000, clk cycles a prefix state may persist before the decoder abandons it

Ports:
- `clk`  in  1  system clock (CLOCK_50)
- `rst`  in  1  reset, asynchronous, active-high
- `ps2_data`  in  8  received byte from the PS/2 controller
- `ps2_valid`  in  1  one-cycle strobe; `ps2_data` valid
- `vga_vs`  in  1  VGA vertical sync, active-low, asynchronous to `clk`
- `enable`  in  1  1 = movement permitted; 0 = positions frozen, key tracking continues
- `xpos`  out  10  player x (to `sendxpos` / textbox)
- `ypos`  out  10  player y
- `held`  out  4  held flags {up, down, left, right}
- `frame_tick`  out  1  one-cycle pulse per detected frame
- `proto_err`  out  1  sticky; set on decoder timeout, cleared only by `rst`

## Operation
- Reset values: `xpos`=X_INIT, `ypos`=Y_INIT, `held`=0, `frame_tick`=0, `proto_err`=0, decoder in IDLE, timeout counter 0, vsync synchronizer flops = 1.
- Key map. Extended (E0-prefixed) codes: 75 up, 72 down, 6B left, 74 right. Plain codes: 1D up (W), 1B down (S), 1C left (A), 23 right (D). Both sources set the same flag.
- Decoder FSM, advancing only on `ps2_valid`:
  - IDLE: E0 → EXT; F0 → BRK; mapped plain code → set flag, stay in IDLE; any other byte → ignored.
  - EXT: F0 → EXT_BRK; mapped extended code → set flag, then IDLE; other byte → IDLE.
  - BRK: mapped plain code → clear flag, then IDLE; other byte → IDLE.
  - EXT_BRK: mapped extended code → clear flag, then IDLE; other byte → IDLE.
  - Typematic repeats of a make code are idempotent.
- Timeout: the counter runs while the FSM is in EXT, BRK or EXT_BRK and resets on every `ps2_valid`. When it reaches TIMEOUT−1, the FSM returns to IDLE and `proto_err` is set. Flags are unchanged.
- Frame step, on `frame_tick` with `enable`=1:
  - dx = right − left; dy = down − up. Opposing keys both held → 0 on that axis.
  - Negative move: if pos < STEP then 0, else pos − STEP.
  - Positive move: if pos > MAX − STEP then MAX, else pos + STEP.
  - Compare in 11 bits; no wrap-around is ever permitted.
- `frame_tick`: `vga_vs` passes through a 2-flop synchronizer, then a falling-edge detector.

## Timing
- `held` changes on the clk edge after the `ps2_valid` cycle.
- `frame_tick` is high 3 clk cycles after the `vga_vs` falling edge (±1 for synchronizer uncertainty).
- `xpos`/`ypos` update on the clk edge closing the `frame_tick` cycle, and hold for the rest of the frame.
- `ps2_valid` and `frame_tick` in the same cycle: the step uses `held` from before the byte; the byte takes effect for the next frame.
- `rst` asserted mid-frame or mid-sequence: all state returns to reset values immediately. A partial sequence is discarded.
- Positions change only on a tick, so the renderer never sees a mid-frame change.

## Structure
- Shared package `vgalab_pkg`:
  - scan-code constants (E0, F0, the 8 mapped codes)
  - decoder state enum {IDLE, EXT, BRK, EXT_BRK}
  - held-flag bit indices UP=3, DOWN=2, LEFT=1, RIGHT=0
- Sub-module `ps2_key_tracker`: decoder FSM, timeout counter, `held` and `proto_err` registers.
- `player_move_ctrl` contains the synchronizer, edge detector, and clamped position registers.

## Test plan
- Reset, then 3 vsync falls with no keys → `xpos`=320, `ypos`=240; `frame_tick` pulses exactly 3 times.
- Bytes E0 74, then 4 frames, then E0 F0 74, then 2 frames → `xpos`=328, `held` returns to 0000; no further motion.
- `ypos` forced near 0 (hold W 125 frames from 240) → reaches 0 and stays 0; never 1023.
- Hold D and right-arrow together, then release only D (F0 23) → `held[0]` clears even though the arrow is still held (single shared flag, documented behaviour). Release the arrow, then press A+D → `xpos` unchanged per frame.
- E0 alone with no byte for TIMEOUT cycles → FSM back in IDLE, `proto_err`=1. A following 75 is treated as an ignored plain byte; `held`=0000.
- `ps2_valid` with byte 1D coincident with `frame_tick` → `ypos` unchanged that frame; decrements by 2 on the next tick. `rst` pulsed mid-frame → `xpos`=320, `ypos`=240, `held`=0.
